// File: rtl/power_load_sequencer_if.sv
// Control/status bundle between the GPIO/debug controller and the load sequencer.
// The controller side is master; the sequencer side is slave.
interface power_load_sequencer_if #(
  parameter int unsigned NUM_BANKS = 16,
  parameter int unsigned CNT_W     = 32
);
  localparam int unsigned LW = $clog2(NUM_BANKS + 1);

  logic                 start;
  logic                 abort;
  logic [CNT_W-1:0]     dwell_cycles;
  logic [CNT_W-1:0]     hold_cycles;
  logic [LW-1:0]        target_level;
  logic [7:0]           repeat_count;
  logic [NUM_BANKS-1:0] bank_en;
  logic [LW-1:0]        level;
  logic                 busy;
  logic                 done;
  logic [3:0]           state_led;

  modport master (
    output start, abort, dwell_cycles, hold_cycles, target_level, repeat_count,
    input  bank_en, level, busy, done, state_led
  );

  modport slave (
    input  start, abort, dwell_cycles, hold_cycles, target_level, repeat_count,
    output bank_en, level, busy, done, state_led
  );
endinterface

// File: rtl/power_load_sequencer.sv
// Ramps the power-consumer toggle banks up, holds, and ramps down in a repeatable
// profile so board rails can be measured at known load steps.
module power_load_sequencer #(
  parameter int unsigned NUM_BANKS = 16,
  parameter int unsigned STEP      = 1,
  parameter int unsigned CNT_W     = 32
) (
  input logic                    clk_in,
  input logic                    rst_n,
  power_load_sequencer_if.slave  bus
);
  localparam int unsigned LW  = $clog2(NUM_BANKS + 1);
  localparam int unsigned LW1 = LW + 1;
  localparam logic [LW:0]        StepW  = LW1'(STEP);
  localparam logic [LW:0]        MaxW   = LW1'(NUM_BANKS);
  localparam logic [CNT_W-1:0]   CntOne = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StRampUp, StHold, StRampDown, StDone} state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        level_q, level_d;
  logic [LW-1:0]        tgt_q, tgt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     dwell_q, dwell_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [7:0]           rep_q, rep_d;
  logic                 inf_q, inf_d;

  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           led_q, led_d;

  logic [LW-1:0]        cfg_tgt;
  logic [CNT_W-1:0]     cfg_dwell, cfg_hold;
  logic [LW:0]          up_sum;
  logic [LW-1:0]        up_lvl, dn_lvl;
  logic                 last_profile;

  // Reload values are stored as N-1 so a zero request behaves like one cycle.
  always_comb begin
    cfg_tgt      = ({1'b0, bus.target_level} > MaxW) ? MaxW[LW-1:0] : bus.target_level;
    cfg_dwell    = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - CntOne;
    cfg_hold     = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - CntOne;
    up_sum       = {1'b0, level_q} + StepW;
    up_lvl       = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[LW-1:0];
    dn_lvl       = ({1'b0, level_q} > StepW) ? level_q - StepW[LW-1:0] : '0;
    last_profile = !inf_q && (rep_q == 8'd1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      level_q   <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      dwell_q   <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      inf_q     <= 1'b0;
      bank_en_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 4'b0001;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      inf_q     <= inf_d;
      bank_en_q <= bank_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    inf_d   = inf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          tgt_d   = cfg_tgt;
          dwell_d = cfg_dwell;
          hold_d  = cfg_hold;
          rep_d   = bus.repeat_count;
          inf_d   = (bus.repeat_count == 8'd0);
          if (cfg_tgt == '0) begin
            state_d = StHold;
            level_d = '0;
            cnt_d   = cfg_hold;
          end else begin
            state_d = StRampUp;
            level_d = ({1'b0, cfg_tgt} > StepW) ? StepW[LW-1:0] : cfg_tgt;
            cnt_d   = cfg_dwell;
          end
        end
      end
      StRampUp: begin
        if (level_q == tgt_q) begin
          state_d = StHold;
          cnt_d   = hold_q;
        end else if (cnt_q == '0) begin
          level_d = up_lvl;
          if (up_lvl == tgt_q) begin
            state_d = StHold;
            cnt_d   = hold_q;
          end else begin
            cnt_d = dwell_q;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHold, StRampDown: begin
        // RAMP_DOWN at level 0 is the trailing cycle of the final profile.
        if (state_q == StRampDown && level_q == '0) begin
          state_d = StDone;
        end else if (cnt_q == '0) begin
          state_d = StRampDown;
          level_d = dn_lvl;
          cnt_d   = dwell_q;
          if (dn_lvl == '0) begin
            if (!last_profile) state_d = StRampUp;
            if (!inf_q) rep_d = rep_q - 8'd1;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.abort && state_q != StIdle) begin
      state_d = StIdle;
      level_d = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bank_en_d = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_en_d[i] = (i < 32'(level_d));
    end
    busy_d = state_d inside {StRampUp, StHold, StRampDown};
    done_d = (state_d == StDone);
    led_d  = 4'b0000;
    unique case (state_d)
      StIdle:     led_d = 4'b0001;
      StRampUp:   led_d = 4'b0010;
      StHold:     led_d = 4'b0100;
      StRampDown: led_d = 4'b1000;
      default:    led_d = 4'b0000;
    endcase
  end

  assign bus.bank_en   = bank_en_q;
  assign bus.level     = level_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_led = led_q;
endmodule

// File: tb/tb_power_load_sequencer.sv
// Bench for power_load_sequencer: directed pins from hand-worked profiles plus randomized
// profiles, all checked every cycle against a queue-based expected-output trace.
module tb_power_load_sequencer;
  localparam int NB      = 16;
  localparam int STEP_TB = 1;
  localparam int CW      = 32;

  localparam int PH_IDLE = 0;
  localparam int PH_UP   = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_DOWN = 3;
  localparam int PH_DONE = 4;

  typedef struct {
    int lvl;
    int ph;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  power_load_sequencer_if #(.NUM_BANKS(NB), .CNT_W(CW)) bus ();

  power_load_sequencer #(
    .NUM_BANKS(NB),
    .STEP     (STEP_TB),
    .CNT_W    (CW)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  item_t q[$];
  item_t cur;
  int    m_tgt, m_dwell, m_hold, m_rem;
  bit    m_inf;
  bit    cmp_en = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    ecount = 0;
  int    base = 0;
  int    done_seen = 0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic push(input int l, input int p);
    item_t it;
    it.lvl = l;
    it.ph  = p;
    q.push_back(it);
  endtask

  // Appends one profile's per-edge (level, phase) trace. A non-first profile starts from
  // the level-0 RAMP_UP entry already emitted by the previous profile.
  task automatic add_profile(input bit first, input bit final_p);
    int l = 0;
    int end_ph = final_p ? PH_DOWN : PH_UP;
    if (first) begin
      if (m_tgt == 0) push(0, PH_HOLD);
      else begin
        l = (STEP_TB < m_tgt) ? STEP_TB : m_tgt;
        push(l, PH_UP);
        if (l == m_tgt) push(l, PH_HOLD);
      end
    end else if (m_tgt == 0) begin
      push(0, PH_HOLD);
    end
    while (l < m_tgt) begin
      for (int k = 0; k < m_dwell - 1; k++) push(l, PH_UP);
      l = (l + STEP_TB < m_tgt) ? l + STEP_TB : m_tgt;
      push(l, (l == m_tgt) ? PH_HOLD : PH_UP);
    end
    for (int k = 0; k < m_hold - 1; k++) push(l, PH_HOLD);
    l = (l > STEP_TB) ? l - STEP_TB : 0;
    push(l, (l == 0) ? end_ph : PH_DOWN);
    while (l > 0) begin
      for (int k = 0; k < m_dwell - 1; k++) push(l, PH_DOWN);
      l = (l > STEP_TB) ? l - STEP_TB : 0;
      push(l, (l == 0) ? end_ph : PH_DOWN);
    end
    if (final_p) push(0, PH_DONE);
  endtask

  task automatic go_idle();
    q.delete();
    cur.lvl = 0;
    cur.ph  = PH_IDLE;
  endtask

  task automatic model_step();
    if (!rst_n) go_idle();
    else if (bus.abort && cur.ph != PH_IDLE) go_idle();
    else if (cur.ph == PH_IDLE) begin
      if (bus.start) begin
        m_tgt   = (int'(bus.target_level) > NB) ? NB : int'(bus.target_level);
        m_dwell = (bus.dwell_cycles == 0) ? 1 : int'(bus.dwell_cycles);
        m_hold  = (bus.hold_cycles == 0) ? 1 : int'(bus.hold_cycles);
        m_inf   = (bus.repeat_count == 0);
        m_rem   = int'(bus.repeat_count);
        add_profile(1'b1, !m_inf && m_rem == 1);
        cur = q.pop_front();
      end
    end else begin
      if (q.size() == 0 && cur.ph != PH_DONE) begin
        if (!m_inf) m_rem--;
        add_profile(1'b0, !m_inf && m_rem == 1);
      end
      if (q.size() > 0) cur = q.pop_front();
      else go_idle();
    end
  endtask

  initial begin
    go_idle();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  function automatic logic [3:0] ph_led(input int ph);
    case (ph)
      PH_IDLE: return 4'b0001;
      PH_UP:   return 4'b0010;
      PH_HOLD: return 4'b0100;
      PH_DOWN: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        logic [15:0] exp_en;
        logic        exp_busy, exp_done;
        exp_en   = 16'((32'd1 << cur.lvl) - 32'd1);
        exp_busy = (cur.ph == PH_UP || cur.ph == PH_HOLD || cur.ph == PH_DOWN);
        exp_done = (cur.ph == PH_DONE);
        if (bus.done) done_seen++;
        checks++;
        if (int'(bus.level) != cur.lvl || bus.bank_en !== exp_en || bus.busy !== exp_busy ||
            bus.done !== exp_done || bus.state_led !== ph_led(cur.ph)) begin
          errors++;
          $display("FAIL model t=%0t: level %0d want %0d, bank_en %h want %h, busy %b want %b, done %b want %b, led %b want %b",
                   $time, bus.level, cur.lvl, bus.bank_en, exp_en, bus.busy, exp_busy,
                   bus.done, exp_done, bus.state_led, ph_led(cur.ph));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic at_edge(input int k);
    while (ecount < base + k) @(negedge clk);
  endtask

  task automatic cfg(input int d, input int h, input int t, input int r);
    bus.dwell_cycles = CW'(d);
    bus.hold_cycles  = CW'(h);
    bus.target_level = 5'(t);
    bus.repeat_count = 8'(r);
  endtask

  task automatic launch();
    @(negedge clk);
    base = ecount;
    bus.start = 1'b1;
    at_edge(1);
    bus.start = 1'b0;
  endtask

  initial begin
    int d0;
    int lim;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cfg(4, 10, 4, 1);
    #1 rst_n = 1'b0;
    #20;
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    chk("reset_level", 32'(bus.level), 32'd0);
    chk("reset_bank_en", 32'(bus.bank_en), 32'd0);
    chk("reset_led", 32'(bus.state_led), 32'b0001);
    chk("reset_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);

    // Single profile; config scrambled right after start must be ignored.
    cfg(4, 10, 4, 1);
    launch();
    chk("p1_level_at1", 32'(bus.level), 32'd1);
    cfg(2, 3, 9, 5);
    at_edge(5);  chk("p1_level_at5", 32'(bus.level), 32'd2);
    at_edge(13); chk("p1_bank_en_hold", 32'(bus.bank_en), 32'h000F);
    chk("p1_led_hold", 32'(bus.state_led), 32'b0100);
    at_edge(23); chk("p1_level_at23", 32'(bus.level), 32'd3);
    at_edge(35); chk("p1_level_at35", 32'(bus.level), 32'd0);
    at_edge(36); chk("p1_done_at36", {30'd0, bus.done, bus.busy}, 32'b10);
    at_edge(37); chk("p1_idle_at37", {27'd0, bus.done, bus.state_led}, 32'b00001);

    // Two repetitions.
    cfg(4, 10, 4, 2);
    d0 = done_seen;
    launch();
    at_edge(35); chk("p2_rampup_at35", {27'd0, bus.level}, 32'd0);
    chk("p2_led_at35", 32'(bus.state_led), 32'b0010);
    at_edge(39); chk("p2_level_at39", 32'(bus.level), 32'd1);
    at_edge(51); chk("p2_hold_at51", 32'(bus.state_led), 32'b0100);
    at_edge(74); chk("p2_done_at74", 32'(bus.done), 32'd1);
    at_edge(80); chk("p2_done_once", 32'(done_seen - d0), 32'd1);

    // Abort during HOLD, then restart.
    cfg(4, 10, 4, 1);
    d0 = done_seen;
    launch();
    at_edge(15); chk("ab_level_hold", 32'(bus.level), 32'd4);
    bus.abort = 1'b1;
    at_edge(16); chk("ab_bank_en", 32'(bus.bank_en), 32'd0);
    chk("ab_led", 32'(bus.state_led), 32'b0001);
    bus.abort = 1'b0;
    at_edge(20); bus.start = 1'b1;
    at_edge(21); chk("ab_restart_level", 32'(bus.level), 32'd1);
    bus.start = 1'b0;
    at_edge(22); bus.abort = 1'b1;
    at_edge(23); bus.abort = 1'b0;
    chk("ab_no_done", 32'(done_seen - d0), 32'd0);

    // Clamped target with zero and unit timers must behave the same.
    for (int v = 0; v < 2; v++) begin
      cfg(v, v, 20, 1);
      launch();
      at_edge(16); chk("clamp_bank_en", 32'(bus.bank_en), 32'hFFFF);
      at_edge(17); chk("clamp_down1", 32'(bus.level), 32'd15);
      at_edge(33); chk("clamp_done", 32'(bus.done), 32'd1);
    end

    // Infinite repetition: ten profiles with no done pulse.
    cfg(1, 1, 2, 0);
    d0 = done_seen;
    launch();
    at_edge(5);  chk("inf_level_at5", 32'(bus.level), 32'd1);
    at_edge(41); chk("inf_busy", 32'(bus.busy), 32'd1);
    chk("inf_no_done", 32'(done_seen - d0), 32'd0);
    bus.abort = 1'b1;
    at_edge(42); bus.abort = 1'b0;

    // Asynchronous reset mid RAMP_UP clears outputs without a clock edge.
    cfg(4, 4, 8, 1);
    launch();
    at_edge(6); chk("rst_level_before", 32'(bus.level), 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_bank_en", 32'(bus.bank_en), 32'd0);
    chk("rst_async_led", 32'(bus.state_led), 32'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized profiles with config churn while busy and occasional aborts.
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 3));
      bus.abort = 1'b0;
      bus.start = 1'b1;
      lim = 0;
      do begin
        @(negedge clk);
        lim++;
        cfg($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 3));
        bus.start = ($urandom_range(0, 7) == 0);
        bus.abort = (m_inf && lim > 300) || ($urandom_range(0, 399) == 0);
      end while (cur.ph != PH_IDLE && lim < 5000);
      checks++;
      if (lim >= 5000) begin
        errors++;
        $display("FAIL rand_timeout: profile %0d still busy after %0d cycles, expected idle", it, lim);
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
